// File: rtl/fifo_skew_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_skew_ctrl_if
// Handshake and flag bundle between the row-FIFO sequencing controller and the
// rest of the MMU feed path.
//   start_i / len_i      : tile start request and tile length (1..FIFO_DEPTH)
//   in_valid_i/in_ready_o: upstream vector handshake
//   full_i / empty_i     : per-FIFO status flags
//   wren_o / rden_o      : per-FIFO write/read enables
//   busy_o/done_o/err_o  : controller status
// Modports: slave = controller side, master = the side driving requests/flags.
// -----------------------------------------------------------------------------
interface fifo_skew_ctrl_if #(
    parameter int NUM_FIFO   = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                start_i;
    logic [LW-1:0]       len_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [NUM_FIFO-1:0] full_i;
    logic [NUM_FIFO-1:0] empty_i;
    logic [NUM_FIFO-1:0] wren_o;
    logic [NUM_FIFO-1:0] rden_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    modport slave (
        input  start_i, len_i, in_valid_i, full_i, empty_i,
        output in_ready_o, wren_o, rden_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, len_i, in_valid_i, full_i, empty_i,
        input  in_ready_o, wren_o, rden_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/fifo_skew_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_skew_ctrl
// Sequencer for the bank of row FIFOs feeding the systolic array. Loads one
// tile of len vectors into all rows in lockstep, then drains with a one-cycle
// diagonal skew per row (row i reads in drain cycles i .. i+len-1).
//   clk, rst_n : clock, asynchronous active-low reset (shared with the FIFOs)
//   bus        : fifo_skew_ctrl_if.slave (start/len, upstream handshake,
//                FIFO flags, FIFO enables, busy/done/err status)
// Optional feature: define FIFO_SKEW_UNDERFLOW_CHK_EN to gate each read with
// its FIFO's empty flag and raise a sticky err_o when a scheduled read finds
// the FIFO empty. Without it, reads follow the schedule and err_o is 0.
// -----------------------------------------------------------------------------
module fifo_skew_ctrl #(
    parameter int NUM_FIFO   = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_skew_ctrl_if.slave   bus
);
    localparam int LW   = $clog2(FIFO_DEPTH) + 1;
    localparam int TMAX = FIFO_DEPTH + NUM_FIFO - 2;
    localparam int TW   = $clog2(TMAX + 1);
    // One extra bit so i + len_q cannot overflow in the schedule compare.
    localparam int CW   = TW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       len_q, wr_cnt_q;
    logic [TW-1:0]       t_cnt_q;
    logic                busy_q, done_q;
    logic                start_ok, any_full, hs, last_wr, last_rd;
    logic [NUM_FIFO-1:0] sched;

    assign any_full = |bus.full_i;
    assign start_ok = bus.start_i && (bus.len_i != '0) && (bus.len_i <= LW'(FIFO_DEPTH));
    assign hs       = (state_q == LOAD) && bus.in_valid_i && !any_full;
    assign last_wr  = (wr_cnt_q + LW'(1)) == len_q;
    assign last_rd  = CW'(t_cnt_q) == (CW'(len_q) + CW'(NUM_FIFO - 2));

    // Diagonal drain schedule: row i reads while t_cnt is in [i, i+len_q).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        sched = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            sched[i] = (state_q == DRAIN)
                    && (CW'(t_cnt_q) >= CW'(i))
                    && (CW'(t_cnt_q) <  CW'(i) + CW'(len_q));
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok)      state_d = LOAD;
            LOAD:    if (hs && last_wr) state_d = DRAIN;
            DRAIN:   if (last_rd)       state_d = DONE;
            DONE:                       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            wr_cnt_q <= '0;
            t_cnt_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == LOAD) || (state_d == DRAIN);
            done_q  <= (state_d == DONE);
            unique case (state_q)
                IDLE: if (start_ok) begin
                    len_q    <= bus.len_i;
                    wr_cnt_q <= '0;
                    t_cnt_q  <= '0;
                end
                LOAD:  if (hs)       wr_cnt_q <= wr_cnt_q + LW'(1);
                DRAIN: if (!last_rd) t_cnt_q  <= t_cnt_q + TW'(1);
                default: ;
            endcase
        end
    end

    // A single full flag stalls the whole bank so rows never drift apart.
    assign bus.in_ready_o = (state_q == LOAD) && !any_full;
    assign bus.wren_o     = {NUM_FIFO{hs}};
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;

`ifdef FIFO_SKEW_UNDERFLOW_CHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && start_ok) begin
            err_q <= 1'b0;
        end else if (|(sched & bus.empty_i)) begin
            err_q <= 1'b1;
        end
    end

    // The schedule keeps advancing; an empty row simply skips its read.
    assign bus.rden_o = sched & ~bus.empty_i;
    assign bus.err_o  = err_q;
`else
    assign bus.rden_o = sched;
    assign bus.err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_skew_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_skew_ctrl
// Self-checking bench for fifo_skew_ctrl with NUM_FIFO=4, FIFO_DEPTH=8.
// A behavioural model (tile phase, write count, drain time) predicts every
// output each cycle; directed scenarios pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_fifo_skew_ctrl;
    localparam int N  = 4;
    localparam int D  = 8;
    localparam int LW = $clog2(D) + 1;
`ifdef FIFO_SKEW_UNDERFLOW_CHK_EN
    localparam bit UF_CHK = 1'b1;
`else
    localparam bit UF_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_skew_ctrl_if #(.NUM_FIFO(N), .FIFO_DEPTH(D)) bus ();

    fifo_skew_ctrl #(.NUM_FIFO(N), .FIFO_DEPTH(D)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // phase: 0 idle, 1 loading, 2 draining, 3 done pulse
    int       m_phase = 0;
    int       m_len = 0, m_wr = 0, m_t = 0;
    bit       m_err = 1'b0;
    int       sb_wr = 0;
    int       sb_rd [N];
    int       m_gated [N];

    always @(negedge clk) begin
        logic          e_ready;
        logic [N-1:0]  e_wren, e_sched, e_rden;
        logic          hs;
        if (!rst_n) begin
            m_phase = 0;
            m_err   = 1'b0;
            check("rst_ready", bus.in_ready_o, 0);
            check("rst_wren",  bus.wren_o,     0);
            check("rst_rden",  bus.rden_o,     0);
            check("rst_busy",  bus.busy_o,     0);
            check("rst_done",  bus.done_o,     0);
            check("rst_err",   bus.err_o,      0);
        end else begin
            e_ready = (m_phase == 1) && (bus.full_i == '0);
            hs      = e_ready && bus.in_valid_i;
            e_wren  = hs ? '1 : '0;
            for (int i = 0; i < N; i++)
                e_sched[i] = (m_phase == 2) && (m_t >= i) && (m_t < i + m_len);
            e_rden = UF_CHK ? (e_sched & ~bus.empty_i) : e_sched;

            check("ready", bus.in_ready_o, e_ready);
            check("wren",  bus.wren_o,     e_wren);
            check("rden",  bus.rden_o,     e_rden);
            check("busy",  bus.busy_o,     (m_phase == 1) || (m_phase == 2));
            check("done",  bus.done_o,     m_phase == 3);
            check("err",   bus.err_o,      m_err);

            // Scoreboard: a completed tile wrote len vectors and each row read
            // len entries minus the reads suppressed by empty gating.
            if (m_phase == 1 && bus.wren_o == '1) sb_wr++;
            if (m_phase == 2)
                for (int i = 0; i < N; i++) begin
                    sb_rd[i] += int'(bus.rden_o[i]);
                    m_gated[i] += int'(UF_CHK && e_sched[i] && bus.empty_i[i]);
                end
            if (m_phase == 3) begin
                check("tile_writes", sb_wr, m_len);
                for (int i = 0; i < N; i++)
                    check($sformatf("tile_reads_row%0d", i), sb_rd[i], m_len - m_gated[i]);
            end

            case (m_phase)
                0: if (bus.start_i && bus.len_i >= 1 && bus.len_i <= D) begin
                       m_len = int'(bus.len_i);
                       m_wr = 0; m_t = 0; m_err = 1'b0; sb_wr = 0;
                       for (int i = 0; i < N; i++) begin sb_rd[i] = 0; m_gated[i] = 0; end
                       m_phase = 1;
                   end
                1: if (hs) begin
                       m_wr++;
                       if (m_wr == m_len) m_phase = 2;
                   end
                2: begin
                       if (UF_CHK && |(e_sched & bus.empty_i)) m_err = 1'b1;
                       if (m_t == m_len + N - 2) m_phase = 3;
                       else m_t++;
                   end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] w_log [32];
    logic [N-1:0] r_log [32];
    logic         b_log [32];
    logic         d_log [32];
    logic         y_log [32];

    task automatic idle_inputs();
        bus.start_i = 1'b0; bus.len_i = '0; bus.in_valid_i = 1'b0;
        bus.full_i = '0; bus.empty_i = '0;
    endtask

    task automatic launch(input int len);
        bus.start_i = 1'b1;
        bus.len_i   = LW'(len);
        step();
        bus.start_i = 1'b0;
    endtask

    task automatic sample(input int c);
        @(negedge clk);
        w_log[c] = bus.wren_o;
        r_log[c] = bus.rden_o;
        b_log[c] = bus.busy_o;
        d_log[c] = bus.done_o;
        y_log[c] = bus.in_ready_o;
    endtask

    initial begin
        logic [N-1:0] skew_exp [6];
        int cnt_a, cnt_b, cnt_c;
        bit seen;
        skew_exp = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Basic skew, len=3.
        bus.in_valid_i = 1'b1;
        launch(3);
        for (int c = 0; c < 10; c++) begin sample(c); step(); end
        bus.in_valid_i = 1'b0;
        cnt_a = 0;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("basic_wren_c%0d", c), w_log[c], (c < 3) ? 4'hF : 4'h0);
            cnt_a += int'(b_log[c]);
        end
        for (int k = 0; k < 6; k++)
            check($sformatf("basic_rden_d%0d", k), r_log[k + 3], skew_exp[k]);
        check("basic_done_c9", d_log[9], 1);
        check("basic_busy_cycles", cnt_a, 9);

        // Full stall, len=8, full_i[2] during LOAD cycles 3..5.
        bus.in_valid_i = 1'b1;
        launch(8);
        for (int c = 0; c < 25; c++) begin
            bus.full_i = (c >= 2 && c <= 4) ? 4'b0100 : 4'b0000;
            sample(c);
            step();
        end
        bus.full_i = '0;
        bus.in_valid_i = 1'b0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int c = 0; c < 25; c++) begin
            cnt_a += int'(w_log[c] == 4'hF);
            cnt_b += int'(r_log[c] != 4'h0);
            cnt_c += int'(d_log[c]);
        end
        for (int c = 2; c <= 4; c++) begin
            check($sformatf("stall_ready_c%0d", c), y_log[c], 0);
            check($sformatf("stall_wren_c%0d", c), w_log[c], 0);
        end
        check("stall_writes", cnt_a, 8);
        check("stall_drain_cycles", cnt_b, 11);
        check("stall_done_pulses", cnt_c, 1);

        // Illegal lengths are ignored.
        launch(0);
        step();
        @(negedge clk);
        check("len0_busy", bus.busy_o, 0);
        step();
        launch(9);
        step();
        @(negedge clk);
        check("len9_busy", bus.busy_o, 0);
        step();

        // Start pulsed during DRAIN is ignored.
        bus.in_valid_i = 1'b1;
        launch(2);
        for (int c = 0; c < 10; c++) begin
            bus.start_i = (c == 3);
            bus.len_i   = LW'(5);
            sample(c);
            step();
        end
        bus.start_i = 1'b0;
        bus.in_valid_i = 1'b0;
        cnt_b = 0; cnt_c = 0;
        for (int c = 0; c < 10; c++) begin
            cnt_b += int'(r_log[c] != 4'h0);
            cnt_c += int'(d_log[c]);
        end
        check("ign_drain_cycles", cnt_b, 5);
        check("ign_done_pulses", cnt_c, 1);
        check("ign_busy_after", b_log[9], 0);

        // Bubbled input, len=2, valid 1,0,1.
        launch(2);
        for (int c = 0; c < 6; c++) begin
            bus.in_valid_i = (c == 0 || c == 2);
            sample(c);
            step();
        end
        bus.in_valid_i = 1'b0;
        check("bubble_wren_c0", w_log[0], 4'hF);
        check("bubble_wren_c1", w_log[1], 4'h0);
        check("bubble_wren_c2", w_log[2], 4'hF);
        check("bubble_wren_c3", w_log[3], 4'h0);
        check("bubble_rden_c3", r_log[3], 4'h1);
        repeat (4) step();

        // Reset in DRAIN cycle 2.
        bus.in_valid_i = 1'b1;
        launch(3);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("mrst_ready", bus.in_ready_o, 0);
        check("mrst_wren",  bus.wren_o, 0);
        check("mrst_rden",  bus.rden_o, 0);
        check("mrst_busy",  bus.busy_o, 0);
        check("mrst_done",  bus.done_o, 0);
        check("mrst_err",   bus.err_o, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        launch(5);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            seen = bus.done_o;
            step();
        end
        check("post_reset_tile_done", seen, 1);
        bus.in_valid_i = 1'b0;
        step();

`ifdef FIFO_SKEW_UNDERFLOW_CHK_EN
        // Underflow on row 1 during the whole DRAIN (len=4 -> cycles 4..10).
        bus.in_valid_i = 1'b1;
        launch(4);
        for (int c = 0; c < 14; c++) begin
            bus.empty_i = (c >= 4 && c <= 10) ? 4'b0010 : 4'b0000;
            sample(c);
            step();
        end
        bus.in_valid_i = 1'b0;
        cnt_a = 0;
        for (int c = 4; c <= 10; c++) cnt_a += int'(r_log[c][1]);
        check("uf_row1_reads", cnt_a, 0);
        @(negedge clk);
        check("uf_err_sticky", bus.err_o, 1);
        step();
        launch(1);
        @(negedge clk);
        check("uf_err_cleared", bus.err_o, 0);
        repeat (8) step();
`endif

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.start_i    = ($urandom % 5) == 0;
            bus.len_i      = LW'($urandom % 10);
            bus.in_valid_i = ($urandom % 4) != 0;
            bus.full_i     = (($urandom % 8) == 0) ? N'($urandom) : '0;
            bus.empty_i    = (($urandom % 8) == 0) ? N'($urandom) : '0;
            step();
        end
        idle_inputs();
        repeat (30) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
